pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall controller for the five-stage pipeline (fetch, decode, execute, memory, writeback). It drives the per-stage stall inputs `s_fe`..`s_wb` from three sources: load-use hazard detection, memory wait, and a debug halt/single-step state machine. It also keeps a saturating stall-cycle performance counter. It sits beside the pipeline top level, reads hazard fields from the decode and execute stages, and replaces the externally tied stall inputs.

## Interface
- `DRAIN`, default 4: cycles needed to empty the pipeline behind a stalled fetch.
- `CW`, default 16: width of the stall counter.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_is_load` in 1: execute stage holds a valid load.
- `ex_rd` in 5: destination register of the execute-stage instruction.
- `dc_rs1`, `dc_rs2` in 5 each: source registers of the decode-stage instruction.
- `dc_use_rs1`, `dc_use_rs2` in 1 each: the decode-stage instruction reads that source.
- `mem_busy` in 1: the memory stage is waiting on the data port.
- `halt_req`, `step_req`, `resume_req` in 1 each: debug requests, level-sampled.
- `cnt_clr` in 1: synchronous clear of `stall_cnt`.
- `s_fe`, `s_dc`, `s_ex`, `s_me`, `s_wb` out 1 each: stage stalls; 1 holds that stage's registers.
- `halted` out 1: pipeline is fully stopped under debug control.
- `stall_cnt` out `CW`: count of RUN-state cycles with `s_fe`=1.

## Operation
- **Load-use hazard** `lu`: `ex_is_load` AND `ex_rd`≠0 AND ((`dc_use_rs1` AND `dc_rs1`==`ex_rd`) OR (`dc_use_rs2` AND `dc_rs2`==`ex_rd`)).
- **Monotone stall rule:** if stage k is stalled, every earlier stage is stalled. The outputs always form a prefix: fe, fe+dc, …, all five.
- **Base stall**, applied in RUN and in HALTING:
  - `mem_busy`: stall fe, dc, ex, me. wb runs, so a bubble is inserted.
  - else `lu`: stall fe, dc. Execute receives a bubble.
  - else: no stall.
  - `mem_busy` has priority over `lu`.
- **FSM states** (state in `pipe_pkg`): RUN, HALTING, HALTED, STEP.
  - RUN: outputs = base stall. `halt_req`=1 → HALTING, with the drain counter loaded to `DRAIN`.
  - HALTING: `s_fe` forced to 1; the remaining outputs are the base stall. The drain counter decrements in each cycle with `mem_busy`=0 and holds otherwise. At counter==1 with `mem_busy`=0 → HALTED.
  - HALTED: all five stalls = 1 and `halted`=1.
    - `resume_req` → RUN.
    - else `step_req` → STEP.
    - `resume_req` wins over a simultaneous `step_req`.
  - STEP: exactly one cycle with all stalls = 0, fetching one instruction. Then → HALTING with the counter reloaded to `DRAIN`.
  - Requests not named for the current state are ignored. In particular, `halt_req` in HALTING, HALTED or STEP does nothing.
- **Counter:** `stall_cnt` increments in each RUN cycle with `s_fe`=1 and saturates at all-ones. `cnt_clr` clears it and wins over an increment in the same cycle.

## Timing
- State, drain counter and `stall_cnt` are registered.
- Stall outputs are combinational from the registered state plus the same-cycle hazard inputs, so there are zero cycles of latency from `lu`/`mem_busy` to the stalls.
- `halted` is decoded from registered state only.
- **Reset:** state=RUN, drain counter=0, `stall_cnt`=0, `halted`=0. With hazard inputs low, all `s_*`=0.
- **Reset mid-operation** (for example during HALTING or STEP) aborts to RUN immediately and asynchronously.
- **halt_req** sampled at edge N → HALTING from N+1. With no `mem_busy`, HALTED (`halted`=1) from N+1+`DRAIN`.
- **step_req** in HALTED at edge N → STEP for cycle N+1 → HALTING → HALTED again at N+2+`DRAIN`.
- **resume_req** in HALTED at edge N → RUN from N+1, stalls released in the same cycle.

## Structure
- `pipe_pkg` holds:
  - the state enum;
  - the default `DRAIN` (4);
  - the register index width (5);
  - the stage-order constants used to build prefix masks.
- One combinational sub-module, `hazard_detect`, computes `lu` (comparators plus zero-register check).
- The FSM, stall prefix encoding and counter live in `pipe_ctrl`.

## Test plan
- **Reset:** assert `rst` mid-HALTING → `halted`=0, state RUN, `stall_cnt`=0, all `s_*`=0 without a clock edge.
- **Load-use:**
  - `ex_is_load`=1, `ex_rd`=5, `dc_rs2`=5, `dc_use_rs2`=1 → `s_fe`=`s_dc`=1, rest 0, and `stall_cnt` increments by 1.
  - Same with `ex_rd`=0 → no stall.
- **Priority:** `mem_busy`=1 together with the load-use case → `s_fe`..`s_me`=1, `s_wb`=0.
- **Halt with memory wait:** `halt_req` at edge 10 with `DRAIN`=4 and `mem_busy` high for 2 cycles inside HALTING → `halted`=1 from cycle 17, not 15.
- **Step and request collisions:**
  - From HALTED, one `step_req` → exactly one cycle of all stalls = 0, then `halted` returns after 1+`DRAIN` cycles.
  - `step_req` and `resume_req` together in HALTED → RUN.
- **Counter:** preload near saturation by holding `lu` for 2^`CW`+3 cycles → `stall_cnt`=0xFFFF. Then `cnt_clr` asserted together with `lu` → 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTING = 2'd1,
        ST_HALTED  = 2'd2,
        ST_STEP    = 2'd3
    } state_t;

    localparam int unsigned DRAIN_DEF = 4;
    localparam int unsigned REG_W     = 5;

    // Stage order, earliest first; a stall depth of d stalls stages [0, d).
    localparam int unsigned STG_FE = 0;
    localparam int unsigned STG_DC = 1;
    localparam int unsigned STG_EX = 2;
    localparam int unsigned STG_ME = 3;
    localparam int unsigned STG_WB = 4;
    localparam int unsigned NSTG   = 5;

    localparam int unsigned DEPTH_W = 3;
    typedef logic [DEPTH_W-1:0] depth_t;

    localparam depth_t D_NONE = depth_t'(0);
    localparam depth_t D_FE   = depth_t'(STG_FE + 1);
    localparam depth_t D_LU   = depth_t'(STG_DC + 1);
    localparam depth_t D_MEM  = depth_t'(STG_ME + 1);
    localparam depth_t D_ALL  = depth_t'(NSTG);

    function automatic logic [NSTG-1:0] prefix_mask(input depth_t depth);
        logic [NSTG-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NSTG; i++) begin
            m[i] = (DEPTH_W'(i) < depth);
        end
        return m;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between execute-stage load and decode-stage sources.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] dc_rs1,
    input  logic [REG_W-1:0] dc_rs2,
    input  logic             dc_use_rs1,
    input  logic             dc_use_rs2,
    output logic             lu_c
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = dc_use_rs1 && (dc_rs1 == ex_rd);
    assign hit_rs2 = dc_use_rs2 && (dc_rs2 == ex_rd);
    // x0 never carries a real dependency
    assign lu_c    = ex_is_load && (ex_rd != '0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall controller: hazard/memory stalls, debug halt/step FSM and stall counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DRAIN = DRAIN_DEF,
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] dc_rs1,
    input  logic [REG_W-1:0] dc_rs2,
    input  logic             dc_use_rs1,
    input  logic             dc_use_rs2,
    input  logic             mem_busy,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    input  logic             cnt_clr,
    output logic             s_fe,
    output logic             s_dc,
    output logic             s_ex,
    output logic             s_me,
    output logic             s_wb,
    output logic             halted,
    output logic [CW-1:0]    stall_cnt
);

    localparam int unsigned DW = $clog2(DRAIN + 1);

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   drain;
    logic [DW-1:0]   drain_nxt;
    logic            lu;
    depth_t          base_depth;
    depth_t          depth;
    logic [NSTG-1:0] stall_mask;

    hazard_detect u_hazard (
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .dc_rs1     (dc_rs1),
        .dc_rs2     (dc_rs2),
        .dc_use_rs1 (dc_use_rs1),
        .dc_use_rs2 (dc_use_rs2),
        .lu_c       (lu)
    );

    // Memory wait outranks load-use
    assign base_depth = mem_busy ? D_MEM : (lu ? D_LU : D_NONE);

    // State and drain counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            drain <= '0;
        end else begin
            state <= state_nxt;
            drain <= drain_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        drain_nxt = drain;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt = ST_HALTING;
                    drain_nxt = DW'(DRAIN);
                end
            end
            ST_HALTING: begin
                if (!mem_busy) begin
                    drain_nxt = drain - DW'(1);
                    if (drain == DW'(1)) begin
                        state_nxt = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (resume_req) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                state_nxt = ST_HALTING;
                drain_nxt = DW'(DRAIN);
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output decode: stall depth per state, halted from state only
    always_comb begin
        depth  = D_NONE;
        halted = 1'b0;
        case (state)
            ST_RUN:     depth = base_depth;
            ST_HALTING: depth = (base_depth > D_FE) ? base_depth : D_FE;
            ST_HALTED: begin
                depth  = D_ALL;
                halted = 1'b1;
            end
            ST_STEP:    depth = D_NONE;
            default:    depth = D_NONE;
        endcase
    end

    assign stall_mask = prefix_mask(depth);
    assign s_fe = stall_mask[STG_FE];
    assign s_dc = stall_mask[STG_DC];
    assign s_ex = stall_mask[STG_EX];
    assign s_me = stall_mask[STG_ME];
    assign s_wb = stall_mask[STG_WB];

    // Saturating count of RUN cycles with fetch stalled; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if ((state == ST_RUN) && s_fe && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle reference model plus directed timing checks.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int unsigned DRAIN = 4;
    localparam int unsigned CW    = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_is_load;
    logic [4:0]    ex_rd, dc_rs1, dc_rs2;
    logic          dc_use_rs1, dc_use_rs2;
    logic          mem_busy, halt_req, step_req, resume_req, cnt_clr;
    logic          s_fe, s_dc, s_ex, s_me, s_wb, halted;
    logic [CW-1:0] stall_cnt;
    logic [4:0]    got_s;

    typedef struct packed {
        logic [4:0]    s;
        logic          h;
        logic [CW-1:0] c;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_st, m_drain, m_cnt;

    always #5 clk = ~clk;

    assign got_s = {s_wb, s_me, s_ex, s_dc, s_fe};

    pipe_ctrl #(.DRAIN(DRAIN), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .dc_rs1(dc_rs1), .dc_rs2(dc_rs2),
        .dc_use_rs1(dc_use_rs1), .dc_use_rs2(dc_use_rs2),
        .mem_busy(mem_busy), .halt_req(halt_req), .step_req(step_req),
        .resume_req(resume_req), .cnt_clr(cnt_clr),
        .s_fe(s_fe), .s_dc(s_dc), .s_ex(s_ex), .s_me(s_me), .s_wb(s_wb),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_lu();
        return ex_is_load && (ex_rd != 5'd0) &&
               ((dc_use_rs1 && dc_rs1 == ex_rd) || (dc_use_rs2 && dc_rs2 == ex_rd));
    endfunction

    // Expected {wb,me,ex,dc,fe} for the current model state and inputs
    function automatic logic [4:0] m_stalls();
        logic [4:0] base;
        base = mem_busy ? 5'b01111 : (m_lu() ? 5'b00011 : 5'b00000);
        case (m_st)
            0:       return base;
            1:       return base | 5'b00001;
            2:       return 5'b11111;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_drain = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [4:0] s;
        s = m_stalls();
        if (cnt_clr) m_cnt = 0;
        else if (m_st == 0 && s[0] && m_cnt != CNT_MAX) m_cnt++;
        case (m_st)
            0: if (halt_req) begin m_st = 1; m_drain = DRAIN; end
            1: if (!mem_busy) begin
                   if (m_drain == 1) m_st = 2;
                   m_drain--;
               end
            2: if (resume_req) m_st = 0; else if (step_req) m_st = 3;
            default: begin m_st = 1; m_drain = DRAIN; end
        endcase
    endtask

    task automatic idle();
        ex_is_load = 0; ex_rd = 0; dc_rs1 = 0; dc_rs2 = 0;
        dc_use_rs1 = 0; dc_use_rs2 = 0; mem_busy = 0;
        halt_req = 0; step_req = 0; resume_req = 0; cnt_clr = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs2);
        ex_is_load = 1; ex_rd = rd; dc_rs2 = rs2; dc_use_rs2 = 1;
    endtask

    // One clock: push expectation, compare at negedge, advance model at posedge
    task automatic cycle(input bit do_chk);
        exp_t e;
        if (do_chk) begin
            e.s = m_stalls();
            e.h = (m_st == 2);
            e.c = m_cnt[CW-1:0];
            sb_q.push_back(e);
        end
        @(negedge clk);
        if (do_chk) begin
            e = sb_q.pop_front();
            chk("stalls", 32'(got_s), 32'(e.s));
            chk("halted", 32'(halted), 32'(e.h));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.c));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros, ret;
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stalls", 32'(got_s), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        rst = 0;

        // Load-use on rs2, then x0 and non-matching variants
        set_lu(5'd5, 5'd5);
        cycle(1);
        idle();
        chk("lu_cnt_inc", 32'(stall_cnt), 32'd1);
        cycle(1);
        set_lu(5'd0, 5'd0);
        cycle(1);
        chk("lu_x0_stalls", 32'(got_s), 32'd0);
        idle(); ex_is_load = 1; ex_rd = 7; dc_rs1 = 7; dc_use_rs1 = 1;
        cycle(1);
        dc_use_rs1 = 0;
        cycle(1);
        idle(); ex_rd = 9; dc_rs1 = 9; dc_use_rs1 = 1;
        cycle(1);

        // mem_busy outranks load-use
        idle(); set_lu(5'd5, 5'd5); mem_busy = 1;
        #1 chk("prio_stalls", 32'(got_s), 32'b01111);
        cycle(1);

        for (int i = 0; i < 40; i++) begin
            idle();
            ex_is_load = 1'($urandom_range(0, 1));
            ex_rd      = 5'($urandom_range(0, 3));
            dc_rs1     = 5'($urandom_range(0, 3));
            dc_rs2     = 5'($urandom_range(0, 3));
            dc_use_rs1 = 1'($urandom_range(0, 1));
            dc_use_rs2 = 1'($urandom_range(0, 1));
            mem_busy   = ($urandom_range(0, 3) == 0);
            cnt_clr    = ($urandom_range(0, 15) == 0);
            cycle(1);
        end

        // Halt with two mem_busy cycles inside HALTING
        idle(); halt_req = 1;
        cycle(1);
        ret = -1;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (halted) begin ret = i; break; end
            if (i == 0) set_lu(5'd3, 5'd3);
            mem_busy = (i == 1 || i == 2);
            cycle(1);
        end
        chk("halt_latency", 32'(ret), 32'(DRAIN + 2));

        idle(); halt_req = 1;
        cycle(1);
        cycle(1);

        // Single step
        idle(); step_req = 1;
        cycle(1);
        idle();
        zeros = 0; ret = -1;
        for (int i = 0; i < 20; i++) begin
            if (got_s == 5'd0) zeros++;
            if (halted) begin ret = i; break; end
            cycle(1);
        end
        chk("step_zero_cycles", 32'(zeros), 32'd1);
        chk("step_return", 32'(ret), 32'(DRAIN + 1));

        // Step and resume together: resume wins
        step_req = 1; resume_req = 1;
        cycle(1);
        idle();
        chk("collide_halted", 32'(halted), 32'd0);
        cycle(1);
        chk("collide_state", 32'(dut.state), 32'(ST_RUN));

        // Asynchronous reset in the middle of HALTING
        set_lu(5'd2, 5'd2);
        cycle(1);
        idle(); halt_req = 1;
        cycle(1);
        idle();
        cycle(1);
        rst = 1;
        #2;
        chk("mid_rst_halted", 32'(halted), 32'd0);
        chk("mid_rst_stalls", 32'(got_s), 32'd0);
        chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'(ST_RUN));
        model_reset();
        @(posedge clk);
        #1 rst = 0;

        // Saturate the counter, then clear with lu held
        set_lu(5'd6, 5'd6);
        for (int i = 0; i < (1 << CW) + 3; i++) cycle(0);
        chk("cnt_saturate", 32'(stall_cnt), 32'hFFFF);
        cnt_clr = 1;
        cycle(1);
        cnt_clr = 0;
        idle();
        chk("cnt_clear", 32'(stall_cnt), 32'd0);
        cycle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
